ps2_hex_fmt: RTL and testbench

Byte-to-hex-text formatter that sits between the PS/2 receiver (`done`/`data` byte strobe) and the UART transmitter (`tx`/`tx_data`/`tx_full`) on the xvideo keyboard test path. Each received scan-code byte is buffered in a small FIFO, then emitted as two uppercase ASCII hex digits followed by a space. After every `LINE_BYTES` bytes the space is replaced by CR LF. Raw make/break/extended codes (e.g. `E0 F0 1C`) therefore become readable on a terminal without loss when typing bursts outpace the UART.

---
 rtl/ps2_fmt_pkg.sv | 28 ++
 rtl/ps2_hex_fmt_if.sv | 33 +++
 rtl/sync_fifo.sv | 54 +++++
 rtl/ps2_hex_fmt.sv | 136 +++++++++++++
 tb/tb_ps2_hex_fmt.sv | 291 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ps2_fmt_pkg.sv
// Shared types, ASCII constants and the nibble-to-hex helper for the PS/2 hex formatter.
// Both the formatter FSM and anything that decodes its output rely on these definitions.
package ps2_fmt_pkg;

    typedef enum logic [2:0] {
        IDLE,
        HI,
        LO,
        SEP,
        CR,
        LF
    } fmt_state_t;

    localparam logic [7:0] ASC_SP = 8'h20;
    localparam logic [7:0] ASC_CR = 8'h0D;
    localparam logic [7:0] ASC_LF = 8'h0A;
    localparam logic [7:0] ASC_0  = 8'h30;
    localparam logic [7:0] ASC_A  = 8'h41;

    // Uppercase only: the terminal log should match scan-code tables verbatim.
    function automatic logic [7:0] hex_ascii(input logic [3:0] nib);
        if (nib < 4'd10) begin
            return ASC_0 + {4'h0, nib};
        end
        return ASC_A + {4'h0, nib} - 8'd10;
    endfunction

endpackage

// File: rtl/ps2_hex_fmt_if.sv
// Byte-in / character-out signal bundle between the PS/2 receiver, the formatter and the UART TX.
// The master side drives bytes and UART backpressure; the slave side is the formatter.
interface ps2_hex_fmt_if;

    logic       in_valid;
    logic [7:0] in_data;
    logic       tx_full;
    logic       tx;
    logic [7:0] tx_data;
    logic       overflow;
    logic       busy;

    modport master (
        output in_valid,
        output in_data,
        output tx_full,
        input  tx,
        input  tx_data,
        input  overflow,
        input  busy
    );

    modport slave (
        input  in_valid,
        input  in_data,
        input  tx_full,
        output tx,
        output tx_data,
        output overflow,
        output busy
    );

endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO with one extra pointer bit to tell full from empty.
// The head entry is presented combinationally on dout while the FIFO is non-empty.
module sync_fifo #(
    parameter int DW = 8,
    parameter int AW = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic [DW-1:0] din,
    input  logic          pop,
    output logic [DW-1:0] dout,
    output logic          full,
    output logic          empty
);

    logic [DW-1:0] mem_q [2**AW];
    logic [AW:0]   wr_ptr_q;
    logic [AW:0]   wr_ptr_d;
    logic [AW:0]   rd_ptr_q;
    logic [AW:0]   rd_ptr_d;
    logic          do_push;
    logic          do_pop;

    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign dout  = mem_q[rd_ptr_q[AW-1:0]];

    // A pop in the same cycle frees the slot the push is about to overwrite.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, do_push};
        rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, do_pop};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= din;
        end
    end

endmodule

// File: rtl/ps2_hex_fmt.sv
// Turns each buffered PS/2 scan-code byte into "HH " for the UART, ending every
// LINE_BYTES-th byte with CR LF instead of the space.
module ps2_hex_fmt
    import ps2_fmt_pkg::*;
#(
    parameter int FIFO_AW    = 3,
    parameter int LINE_BYTES = 8
) (
    input  logic            clk,
    input  logic            rst,
    ps2_hex_fmt_if.slave    bus
);

    localparam logic [7:0] LAST_IDX = 8'(LINE_BYTES - 1);

    fmt_state_t state_q;
    fmt_state_t state_d;
    logic [7:0] cur_q;
    logic [7:0] cur_d;
    logic [7:0] line_cnt_q;
    logic [7:0] line_cnt_d;
    logic       gap_q;
    logic       gap_d;
    logic       overflow_q;
    logic       overflow_d;
    logic [7:0] tx_data_q;
    logic [7:0] tx_data_d;

    logic       fifo_push;
    logic       fifo_pop;
    logic       fifo_full;
    logic       fifo_empty;
    logic [7:0] fifo_dout;

    logic       char_state;
    logic       issue;
    logic [7:0] emit_char;

    assign fifo_pop  = (state_q == IDLE) && !fifo_empty;
    assign fifo_push = bus.in_valid && (!fifo_full || fifo_pop);

    sync_fifo #(
        .DW (8),
        .AW (FIFO_AW)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (fifo_push),
        .din   (bus.in_data),
        .pop   (fifo_pop),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_comb begin
        emit_char  = 8'h00;
        char_state = 1'b1;
        case (state_q)
            HI:      emit_char = hex_ascii(cur_q[7:4]);
            LO:      emit_char = hex_ascii(cur_q[3:0]);
            SEP:     emit_char = ASC_SP;
            CR:      emit_char = ASC_CR;
            LF:      emit_char = ASC_LF;
            default: char_state = 1'b0;
        endcase
    end

    // tx_full is used unregistered so that it blocks an emit in the very cycle it rises.
    assign issue = char_state && !bus.tx_full && !gap_q;

    always_comb begin
        state_d    = state_q;
        cur_d      = cur_q;
        line_cnt_d = line_cnt_q;
        gap_d      = issue;
        tx_data_d  = issue ? emit_char : tx_data_q;
        overflow_d = overflow_q || (bus.in_valid && fifo_full && !fifo_pop);
        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    cur_d   = fifo_dout;
                    state_d = HI;
                end
            end
            HI: begin
                if (issue) state_d = LO;
            end
            LO: begin
                if (issue) begin
                    if (line_cnt_q == LAST_IDX) begin
                        state_d    = CR;
                        line_cnt_d = 8'd0;
                    end else begin
                        state_d    = SEP;
                        line_cnt_d = line_cnt_q + 8'd1;
                    end
                end
            end
            SEP: begin
                if (issue) state_d = IDLE;
            end
            CR: begin
                if (issue) state_d = LF;
            end
            LF: begin
                if (issue) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            cur_q      <= 8'h00;
            line_cnt_q <= 8'd0;
            gap_q      <= 1'b0;
            overflow_q <= 1'b0;
            tx_data_q  <= 8'h00;
        end else begin
            state_q    <= state_d;
            cur_q      <= cur_d;
            line_cnt_q <= line_cnt_d;
            gap_q      <= gap_d;
            overflow_q <= overflow_d;
            tx_data_q  <= tx_data_d;
        end
    end

    assign bus.tx       = issue;
    assign bus.tx_data  = issue ? emit_char : tx_data_q;
    assign bus.overflow = overflow_q;
    assign bus.busy     = !fifo_empty || (state_q != IDLE);

endmodule

// File: tb/tb_ps2_hex_fmt.sv
// Drives two formatters (8 and 2 bytes per line) with identical traffic and scoreboards
// their character streams against a byte-to-text model of the output format.
module tb_ps2_hex_fmt;

    localparam int LB_A = 8;
    localparam int LB_B = 2;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    ps2_hex_fmt_if busA ();
    ps2_hex_fmt_if busB ();

    ps2_hex_fmt #(.FIFO_AW(3), .LINE_BYTES(LB_A)) dutA (.clk(clk), .rst(rst), .bus(busA));
    ps2_hex_fmt #(.FIFO_AW(3), .LINE_BYTES(LB_B)) dutB (.clk(clk), .rst(rst), .bus(busB));

    int compared = 0;
    int mismatched = 0;

    string digits = "0123456789ABCDEF";

    logic [7:0] expA[$];
    logic [7:0] expB[$];
    logic [7:0] logA[$];
    logic [7:0] logB[$];
    int         byteIdx[2];
    int         outCnt[2];
    logic [7:0] lastCh[2];
    logic       prevTx[2];
    logic       expOverflow;

    logic       obsTx[2];
    logic [7:0] obsData[2];
    logic       obsBusy[2];

    logic [7:0] wantLine[7];
    logic [7:0] wantHex[9];
    logic [7:0] wantFresh[3];

    // Every comparison in the bench funnels through here.
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] hexChar(input int n);
        return digits[n];
    endfunction

    task automatic pushChar(input int which, input logic [7:0] c);
        if (which == 0) expA.push_back(c);
        else            expB.push_back(c);
    endtask

    // A byte becomes two hex digits plus a space, or CR LF when it completes a line.
    task automatic modelAccept(input logic [7:0] b);
        for (int w = 0; w < 2; w++) begin
            int lb;
            lb = (w == 0) ? LB_A : LB_B;
            byteIdx[w]++;
            pushChar(w, hexChar(int'(b) / 16));
            pushChar(w, hexChar(int'(b) % 16));
            if (byteIdx[w] % lb == 0) begin
                pushChar(w, 8'h0D);
                pushChar(w, 8'h0A);
            end else begin
                pushChar(w, 8'h20);
            end
            outCnt[w]++;
        end
    endtask

    task automatic resetModel();
        expA.delete();
        expB.delete();
        for (int w = 0; w < 2; w++) begin
            byteIdx[w] = 0;
            outCnt[w]  = 0;
            lastCh[w]  = 8'h00;
            prevTx[w]  = 1'b0;
        end
        expOverflow = 1'b0;
    endtask

    task automatic scoreDut(input int which, input logic tx, input logic [7:0] data,
                            input logic full, input logic ovf);
        logic [8:0] want;
        check($sformatf("txWhileFull%0d", which), {31'd0, tx & full}, 32'd0);
        if (tx) begin
            check($sformatf("gap%0d", which), {31'd0, prevTx[which]}, 32'd0);
            want = 9'h1FF;
            if (which == 0) begin
                if (expA.size() > 0) want = {1'b0, expA.pop_front()};
                logA.push_back(data);
            end else begin
                if (expB.size() > 0) want = {1'b0, expB.pop_front()};
                logB.push_back(data);
            end
            check($sformatf("char%0d", which), {23'd0, 1'b0, data}, {23'd0, want});
            if (data == 8'h20 || data == 8'h0A) outCnt[which]--;
            lastCh[which] = data;
        end else begin
            check($sformatf("hold%0d", which), {24'd0, data}, {24'd0, lastCh[which]});
        end
        check($sformatf("overflow%0d", which), {31'd0, ovf}, {31'd0, expOverflow});
        prevTx[which] = tx;
    endtask

    task automatic checkOutput();
        obsTx[0]   = busA.tx;
        obsTx[1]   = busB.tx;
        obsData[0] = busA.tx_data;
        obsData[1] = busB.tx_data;
        obsBusy[0] = busA.busy;
        obsBusy[1] = busB.busy;
        scoreDut(0, busA.tx, busA.tx_data, busA.tx_full, busA.overflow);
        scoreDut(1, busB.tx, busB.tx_data, busB.tx_full, busB.overflow);
    endtask

    // One clock cycle: inputs change just after the rising edge, outputs are sampled mid-cycle.
    task automatic applyStimulus(input logic r, input logic v, input logic [7:0] d, input logic f);
        @(posedge clk);
        #1;
        rst           = r;
        busA.in_valid = v;
        busB.in_valid = v;
        busA.in_data  = d;
        busB.in_data  = d;
        busA.tx_full  = f;
        busB.tx_full  = f;
        @(negedge clk);
        checkOutput();
        if (r) resetModel();
    endtask

    task automatic idle(input int n, input logic f);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 8'h00, f);
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        while ((expA.size() > 0 || expB.size() > 0) && n < budget) begin
            applyStimulus(1'b0, 1'b0, 8'h00, 1'b0);
            n++;
        end
        check("drainPending", expA.size() + expB.size(), 0);
        applyStimulus(1'b0, 1'b0, 8'h00, 1'b0);
        check("busyAfterDrainA", {31'd0, obsBusy[0]}, 32'd0);
        check("busyAfterDrainB", {31'd0, obsBusy[1]}, 32'd0);
    endtask

    task automatic waitFirstTx(input int budget);
        int n;
        logic found;
        n = 0;
        found = 1'b0;
        while (!found && n < budget) begin
            applyStimulus(1'b0, 1'b0, 8'h00, 1'b0);
            found = obsTx[0];
            n++;
        end
        check("waitTxTimeout", {31'd0, found}, 32'd1);
    endtask

    initial begin
        wantLine  = '{8'h46, 8'h30, 8'h20, 8'h31, 8'h43, 8'h0D, 8'h0A};
        wantHex   = '{8'h30, 8'h30, 8'h20, 8'h39, 8'h41, 8'h20, 8'h46, 8'h46, 8'h20};
        wantFresh = '{8'h30, 8'h35, 8'h20};

        // Reset with a stray in_valid that must be ignored.
        rst           = 1'b1;
        busA.in_valid = 1'b1;
        busB.in_valid = 1'b1;
        busA.in_data  = 8'h77;
        busB.in_data  = 8'h77;
        busA.tx_full  = 1'b0;
        busB.tx_full  = 1'b0;
        repeat (3) @(posedge clk);
        resetModel();
        applyStimulus(1'b0, 1'b0, 8'h00, 1'b0);
        check("resetTxA", {31'd0, obsTx[0]}, 32'd0);
        check("resetDataA", {24'd0, obsData[0]}, 32'd0);
        check("resetBusyA", {31'd0, obsBusy[0]}, 32'd0);
        check("resetBusyB", {31'd0, obsBusy[1]}, 32'd0);
        idle(12, 1'b0);

        // F0 then 1C: on the two-byte-per-line unit this is one full line.
        logB.delete();
        applyStimulus(1'b0, 1'b1, 8'hF0, 1'b0);
        modelAccept(8'hF0);
        applyStimulus(1'b0, 1'b1, 8'h1C, 1'b0);
        modelAccept(8'h1C);
        drain(100);
        check("lineLenB", logB.size(), 7);
        for (int i = 0; i < 7 && i < logB.size(); i++)
            check($sformatf("lineCharB%0d", i), {24'd0, logB[i]}, {24'd0, wantLine[i]});

        // Single byte latency: characters two, four and six cycles after the strobe.
        applyStimulus(1'b0, 1'b1, 8'h1C, 1'b0);
        modelAccept(8'h1C);
        for (int k = 1; k <= 7; k++) begin
            applyStimulus(1'b0, 1'b0, 8'h00, 1'b0);
            check($sformatf("latTx%0d", k), {31'd0, obsTx[0]},
                  {31'd0, (k == 2 || k == 4 || k == 6) ? 1'b1 : 1'b0});
        end
        check("latBusyA", {31'd0, obsBusy[0]}, 32'd0);
        drain(50);

        // Nibble boundary coverage.
        logA.delete();
        applyStimulus(1'b0, 1'b1, 8'h00, 1'b0);
        modelAccept(8'h00);
        applyStimulus(1'b0, 1'b1, 8'h9A, 1'b0);
        modelAccept(8'h9A);
        applyStimulus(1'b0, 1'b1, 8'hFF, 1'b0);
        modelAccept(8'hFF);
        drain(100);
        check("hexLenA", logA.size(), 9);
        for (int i = 0; i < 9 && i < logA.size(); i++)
            check($sformatf("hexCharA%0d", i), {24'd0, logA[i]}, {24'd0, wantHex[i]});

        // Backpressure held right after the high digit of E0.
        applyStimulus(1'b0, 1'b1, 8'hE0, 1'b0);
        modelAccept(8'hE0);
        waitFirstTx(20);
        for (int i = 0; i < 20; i++) begin
            applyStimulus(1'b0, 1'b0, 8'h00, 1'b1);
            check("holdNoTx", {31'd0, obsTx[0]}, 32'd0);
        end
        applyStimulus(1'b0, 1'b0, 8'h00, 1'b0);
        check("releaseTx", {31'd0, obsTx[0]}, 32'd1);
        check("releaseChar", {24'd0, obsData[0]}, 32'h30);
        drain(50);

        // Random bytes and random backpressure, never outrunning the buffer.
        for (int i = 0; i < 400; i++) begin
            logic       f;
            logic       v;
            logic [7:0] d;
            f = ($urandom_range(0, 2) == 0);
            v = (outCnt[0] < 8) && (outCnt[1] < 8) && ($urandom_range(0, 3) == 0);
            d = 8'($urandom);
            applyStimulus(1'b0, v, d, f);
            if (v) modelAccept(d);
        end
        drain(1500);

        // Overflow: one byte parks in the FSM, eight fill the FIFO, the tenth is dropped.
        idle(2, 1'b1);
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1'b0, 1'b1, 8'(8'h10 + i), 1'b1);
            if (i < 9) modelAccept(8'(8'h10 + i));
        end
        expOverflow = 1'b1;
        idle(3, 1'b1);
        drain(300);

        // Reset one cycle after the high digit of AB; the byte in flight is abandoned.
        applyStimulus(1'b0, 1'b1, 8'hAB, 1'b0);
        modelAccept(8'hAB);
        waitFirstTx(20);
        applyStimulus(1'b1, 1'b1, 8'h55, 1'b0);
        applyStimulus(1'b0, 1'b0, 8'h00, 1'b0);
        check("rstTxA", {31'd0, obsTx[0]}, 32'd0);
        check("rstDataA", {24'd0, obsData[0]}, 32'd0);
        check("rstBusyA", {31'd0, obsBusy[0]}, 32'd0);
        check("rstBusyB", {31'd0, obsBusy[1]}, 32'd0);
        idle(10, 1'b0);
        logA.delete();
        logB.delete();
        applyStimulus(1'b0, 1'b1, 8'h05, 1'b0);
        modelAccept(8'h05);
        drain(50);
        check("freshLenA", logA.size(), 3);
        check("freshLenB", logB.size(), 3);
        for (int i = 0; i < 3 && i < logA.size() && i < logB.size(); i++) begin
            check($sformatf("freshA%0d", i), {24'd0, logA[i]}, {24'd0, wantFresh[i]});
            check($sformatf("freshB%0d", i), {24'd0, logB[i]}, {24'd0, wantFresh[i]});
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
